// File: rtl/c1_arbiter.sv
// c1_arbiter: two-requester arbiter that sequences C1 cache-bus command/address/data phases and collects the response.
module c1_arbiter #(
    parameter int OFFSET_W  = 4,
    parameter int LINE_W    = 15,
    parameter int C1_DATA_W = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [1:0]                       req_valid,
    input  logic [5:0]                       req_cmd,
    input  logic [2*(LINE_W+OFFSET_W)-1:0]   req_addr,
    input  logic [63:0]                      req_wdata,
    output logic [1:0]                       req_done,
    output logic                             req_err,
    output logic [31:0]                      rdata,
    output logic [15:0]                      latency,
    output logic                             c1_own,
    output logic [2:0]                       c1_cmd_out,
    output logic [LINE_W-1:0]                c1_addr_out,
    output logic [C1_DATA_W-1:0]             c1_data_out,
    input  logic [2:0]                       c1_cmd_in,
    input  logic [C1_DATA_W-1:0]             c1_data_in
);
    localparam int AW = LINE_W + OFFSET_W;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] NOP = 3'd0, READ8 = 3'd1, READ32 = 3'd3, WRITE32 = 3'd7, RESPONSE = 3'd7;

    typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, DATA2, WAIT_RESP, RESP2, DONE} state_t;

    state_t         state;
    logic           gnt, last;
    logic [2:0]     cmd;
    logic [AW-1:0]  addr;
    logic [31:0]    wdata;
    logic [TW-1:0]  wcnt;
    logic           g, is_read, is_write;
    logic [2:0]     gcmd;
    logic [AW-1:0]  gaddr;
    logic [31:0]    gwdata;
    logic [15:0]    lat_nx, d16;

    // Tie goes to the requester that was not granted last.
    always_comb begin
        g        = (req_valid == 2'b11) ? ~last : req_valid[1];
        gcmd     = g ? req_cmd[5:3] : req_cmd[2:0];
        gaddr    = g ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
        gwdata   = g ? req_wdata[63:32] : req_wdata[31:0];
        is_read  = (cmd != NOP) && !cmd[2];
        is_write = cmd[2] && (cmd != 3'd4);
        lat_nx   = (latency == 16'hFFFF) ? latency : latency + 16'd1;
        d16      = 16'(c1_data_in);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            gnt         <= 1'b0;
            last        <= 1'b1;
            cmd         <= NOP;
            addr        <= '0;
            wdata       <= '0;
            wcnt        <= '0;
            req_done    <= '0;
            req_err     <= 1'b0;
            rdata       <= '0;
            latency     <= '0;
            c1_own      <= 1'b1;
            c1_cmd_out  <= NOP;
            c1_addr_out <= '0;
            c1_data_out <= '0;
        end else begin
            req_done <= '0;
            case (state)
                IDLE: if (|req_valid) begin
                    gnt     <= g;
                    last    <= g;
                    cmd     <= gcmd;
                    addr    <= gaddr;
                    wdata   <= gwdata;
                    latency <= 16'd1;
                    rdata   <= '0;
                    req_err <= 1'b0;
                    if (gcmd == NOP) begin
                        state    <= DONE;
                        req_done <= {g, ~g};
                        req_err  <= 1'b1;
                    end else begin
                        state       <= ADDR_HI;
                        c1_cmd_out  <= gcmd;
                        c1_addr_out <= gaddr[OFFSET_W +: LINE_W];
                    end
                end
                ADDR_HI: begin
                    state       <= ADDR_LO;
                    latency     <= lat_nx;
                    c1_addr_out <= LINE_W'(addr[OFFSET_W-1:0]);
                    c1_data_out <= is_write ? C1_DATA_W'(wdata[15:0]) : '0;
                end
                ADDR_LO: begin
                    latency <= lat_nx;
                    if (cmd == WRITE32) begin
                        state       <= DATA2;
                        c1_data_out <= C1_DATA_W'(wdata[31:16]);
                    end else begin
                        state       <= WAIT_RESP;
                        c1_own      <= 1'b0;
                        c1_cmd_out  <= NOP;
                        c1_data_out <= '0;
                        wcnt        <= '0;
                    end
                end
                DATA2: begin
                    state       <= WAIT_RESP;
                    latency     <= lat_nx;
                    c1_own      <= 1'b0;
                    c1_cmd_out  <= NOP;
                    c1_data_out <= '0;
                    wcnt        <= '0;
                end
                WAIT_RESP: begin
                    latency <= lat_nx;
                    if (c1_cmd_in == RESPONSE) begin
                        rdata <= (cmd == READ8) ? {24'h0, d16[7:0]} : is_read ? {16'h0, d16} : 32'h0;
                        if (cmd == READ32) begin
                            state <= RESP2;
                        end else begin
                            state    <= DONE;
                            req_done <= {gnt, ~gnt};
                            c1_own   <= 1'b1;
                        end
                    end else if (wcnt == TW'(TIMEOUT - 1)) begin
                        state    <= DONE;
                        req_done <= {gnt, ~gnt};
                        req_err  <= 1'b1;
                        c1_own   <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                RESP2: begin
                    state        <= DONE;
                    latency      <= lat_nx;
                    rdata[31:16] <= d16;
                    req_done     <= {gnt, ~gnt};
                    c1_own       <= 1'b1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_c1_arbiter.sv
// tb_c1_arbiter: directed-vector bench for c1_arbiter with hand-computed expectations.
module tb_c1_arbiter;
    logic        clk = 1'b0, reset = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [2:0]  cmd0 = '0, cmd1 = '0;
    logic [18:0] a0 = '0, a1 = '0;
    logic [31:0] w0 = '0, w1 = '0;
    logic [1:0]  req_done;
    logic        req_err, c1_own;
    logic [31:0] rdata;
    logic [15:0] latency;
    logic [2:0]  c1_cmd_out;
    logic [14:0] c1_addr_out;
    logic [15:0] c1_data_out;
    logic [2:0]  c1_cmd_in = '0;
    logic [15:0] c1_data_in = '0;
    int n_cmp = 0, n_err = 0;

    c1_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_cmd({cmd1, cmd0}),
        .req_addr({a1, a0}), .req_wdata({w1, w0}), .req_done(req_done), .req_err(req_err),
        .rdata(rdata), .latency(latency), .c1_own(c1_own), .c1_cmd_out(c1_cmd_out),
        .c1_addr_out(c1_addr_out), .c1_data_out(c1_data_out), .c1_cmd_in(c1_cmd_in),
        .c1_data_in(c1_data_in)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #12;
        chk("rst_own", c1_own, 1);
        chk("rst_cmd", c1_cmd_out, 0);
        chk("rst_addr", c1_addr_out, 0);
        chk("rst_data", c1_data_out, 0);
        chk("rst_done", req_done, 0);
        chk("rst_err", req_err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_lat", latency, 0);
        tick();
        reset = 1'b1;

        // READ8 from requester 0
        req_valid = 2'b01; cmd0 = 3'd1; a0 = 19'h7AA49;
        tick();
        chk("r8_hi_own", c1_own, 1);
        chk("r8_hi_cmd", c1_cmd_out, 1);
        chk("r8_hi_addr", c1_addr_out, 15'h7AA4);
        tick();
        chk("r8_lo_addr", c1_addr_out, 15'h0009);
        chk("r8_lo_cmd", c1_cmd_out, 1);
        tick();
        chk("r8_w1_own", c1_own, 0);
        chk("r8_w1_cmd", c1_cmd_out, 0);
        tick();
        tick();
        c1_cmd_in = 3'd7; c1_data_in = 16'h00C3;
        tick();
        c1_cmd_in = 3'd0; c1_data_in = 16'h0;
        chk("r8_done", req_done, 2'b01);
        chk("r8_err", req_err, 0);
        chk("r8_rdata", rdata, 32'h000000C3);
        chk("r8_lat", latency, 6);
        chk("r8_d_own", c1_own, 1);
        chk("r8_d_cmd", c1_cmd_out, 0);
        req_valid = 2'b00;
        tick();
        chk("r8_pulse", req_done, 0);

        // WRITE32 from requester 1
        req_valid = 2'b10; cmd1 = 3'd7; a1 = 19'h00120; w1 = 32'hDEADBEEF;
        tick();
        chk("w32_hi_cmd", c1_cmd_out, 7);
        chk("w32_hi_addr", c1_addr_out, 15'h0012);
        tick();
        chk("w32_lo_data", c1_data_out, 16'hBEEF);
        chk("w32_lo_addr", c1_addr_out, 0);
        tick();
        chk("w32_d2_data", c1_data_out, 16'hDEAD);
        chk("w32_d2_own", c1_own, 1);
        tick();
        chk("w32_wait_own", c1_own, 0);
        c1_cmd_in = 3'd7; c1_data_in = 16'h1111;
        tick();
        c1_cmd_in = 3'd0; c1_data_in = 16'h0;
        chk("w32_done", req_done, 2'b10);
        chk("w32_rdata", rdata, 0);
        chk("w32_lat", latency, 5);
        req_valid = 2'b00;
        tick();

        // READ32 two response beats
        req_valid = 2'b01; cmd0 = 3'd3; a0 = 19'h0;
        tick();
        tick();
        tick();
        c1_cmd_in = 3'd7; c1_data_in = 16'h5678;
        tick();
        c1_cmd_in = 3'd0; c1_data_in = 16'h1234;
        chk("r32_resp2_own", c1_own, 0);
        chk("r32_resp2_done", req_done, 0);
        tick();
        c1_data_in = 16'h0;
        chk("r32_done", req_done, 2'b01);
        chk("r32_rdata", rdata, 32'h12345678);
        chk("r32_lat", latency, 5);
        req_valid = 2'b00;
        tick();

        // RESPONSE while idle is ignored
        c1_cmd_in = 3'd7;
        tick();
        tick();
        chk("idle_resp_done", req_done, 0);
        chk("idle_resp_own", c1_own, 1);
        c1_cmd_in = 3'd0;

        // Alternating NOP grants from reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        cmd0 = 3'd0; cmd1 = 3'd0; req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("alt_done", req_done, (i % 2) ? 2'b10 : 2'b01);
            chk("alt_err", req_err, 1);
            chk("alt_lat", latency, 1);
            tick();
            chk("alt_gap", req_done, 0);
        end
        req_valid = 2'b00;
        tick();

        // Timeout on READ16 from requester 1
        req_valid = 2'b10; cmd1 = 3'd2; a1 = 19'h12345; c1_data_in = 16'hFFFF;
        tick();
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("to_wait_own", c1_own, 0);
        chk("to_wait_done", req_done, 0);
        tick();
        chk("to_done", req_done, 2'b10);
        chk("to_err", req_err, 1);
        chk("to_rdata", rdata, 0);
        chk("to_lat", latency, 19);
        req_valid = 2'b00; c1_data_in = 16'h0;
        tick();

        // Async reset during WAIT_RESP, then a clean READ8
        req_valid = 2'b01; cmd0 = 3'd1; a0 = 19'h00013;
        tick();
        tick();
        tick();
        chk("ar_wait_own", c1_own, 0);
        #2 reset = 1'b0;
        #1;
        chk("ar_own", c1_own, 1);
        chk("ar_cmd", c1_cmd_out, 0);
        chk("ar_done", req_done, 0);
        chk("ar_lat", latency, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("ar_hi_cmd", c1_cmd_out, 1);
        chk("ar_hi_addr", c1_addr_out, 15'h0001);
        tick();
        chk("ar_lo_addr", c1_addr_out, 15'h0003);
        tick();
        c1_cmd_in = 3'd7; c1_data_in = 16'h12CD;
        tick();
        c1_cmd_in = 3'd0; c1_data_in = 16'h0;
        chk("ar2_done", req_done, 2'b01);
        chk("ar2_rdata", rdata, 32'h000000CD);
        chk("ar2_lat", latency, 4);
        req_valid = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
